// File: rtl/pixelbox_ddr_pkg.sv
// Shared definitions for the pixelbox DDR read path.
//   sched_state_t  : read-burst scheduler FSM states
//   DDR_BEAT_BYTES : bytes carried by one 256-bit DDR beat
//   min_len()      : length of the next burst given the beats still to fetch
package pixelbox_ddr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    localparam int DDR_BEAT_BYTES = 32;

    function automatic int unsigned min_len(input int unsigned max_len,
                                            input int unsigned remain);
        return (remain < max_len) ? remain : max_len;
    endfunction

endpackage

// File: rtl/rd_burst_sched_if.sv
// DDR read-port bundle between the burst scheduler and the DDR user port.
//   rd_req_valid/rd_req_ready : request handshake
//   rd_req_addr/rd_req_len    : burst start byte address and beat count
//   rd_data_valid             : one returned beat (also the FIFO write enable)
// master = scheduler side, slave = DDR port side.
interface rd_burst_sched_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int LEN_WIDTH  = 7
);
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic [LEN_WIDTH-1:0]  rd_req_len;
    logic                  rd_data_valid;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_len,
        input  rd_req_ready, rd_data_valid
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_len,
        output rd_req_ready, rd_data_valid
    );
endinterface

// File: rtl/beat_credit_cnt.sv
// Outstanding-beat counter for the read scheduler.
//   add_en/add_len : accepted request adds its beat count
//   dec_en         : one returned beat
//   count          : registered outstanding beats
//   count_next     : value count takes at the next edge
//   underflow      : a beat arrived with nothing outstanding (count held at 0)
module beat_credit_cnt #(
    parameter int CNT_WIDTH = 10,
    parameter int LEN_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 add_en,
    input  logic [LEN_WIDTH-1:0] add_len,
    input  logic                 dec_en,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] count_next,
    output logic                 underflow
);
    logic [CNT_WIDTH-1:0] sum;

    // An add and a beat in the same cycle net to +len-1; the add is applied
    // first so a beat arriving with a fresh request never counts as underflow.
    always_comb begin
        sum = count;
        if (add_en) sum = sum + CNT_WIDTH'(add_len);
        underflow = 1'b0;
        if (dec_en) begin
            if (sum == '0) underflow = 1'b1;
            else           sum = sum - 1'b1;
        end
    end

    assign count_next = sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= sum;
    end
endmodule

// File: rtl/rd_burst_sched.sv
// Read-side burst scheduler for the DDR-to-video path. Walks one frame of
// linear DDR addresses per frame_start and issues a burst only when the read
// FIFO can absorb that burst plus every beat already in flight.
//   clk, rst            : DDR user clock, async active-high reset
//   frame_start         : one-cycle pulse, (re)starts a frame at FRAME_BASE
//   fifo_wr_water_level : FIFO write-side fill level
//   fifo_wr_full        : FIFO full flag
//   rd_bus (master)     : read request handshake and returned-beat strobe
//   busy                : FSM not idle
//   frame_done          : one-cycle pulse after the last beat of a frame
//   ovf_err             : sticky; beat into a full FIFO or with nothing owed
module rd_burst_sched
    import pixelbox_ddr_pkg::*;
#(
    parameter int                    ADDR_WIDTH       = 28,
    parameter int                    BEAT_BYTES       = DDR_BEAT_BYTES,
    parameter int                    BURST_LEN        = 16,
    parameter int                    LEN_WIDTH        = 7,
    parameter int                    FIFO_DEPTH_WIDTH = 9,
    parameter int                    FRAME_BEATS      = 61440,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE       = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [FIFO_DEPTH_WIDTH:0] fifo_wr_water_level,
    input  logic                      fifo_wr_full,
    rd_burst_sched_if.master          rd_bus,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      ovf_err
);
    localparam int REMAIN_W   = $clog2(FRAME_BEATS + 1);
    localparam int CNT_W      = FIFO_DEPTH_WIDTH + 1;
    localparam int SUM_W      = FIFO_DEPTH_WIDTH + 2;
    localparam int FIFO_WORDS = 1 << FIFO_DEPTH_WIDTH;

    sched_state_t          state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [REMAIN_W-1:0]   remain;
    logic                  restart_pend;
    logic                  restart;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      cnt_next;
    logic                  underflow;
    logic                  req_accept;
    logic [LEN_WIDTH-1:0]  len_calc;
    logic [SUM_W-1:0]      space_sum;
    logic                  space_ok;
    logic [ADDR_WIDTH-1:0] step;
    logic [REMAIN_W-1:0]   req_len_rem;

    assign len_calc = LEN_WIDTH'(min_len(unsigned'(BURST_LEN), 32'(remain)));

    // Two extra bits keep level + outstanding + len from wrapping.
    assign space_sum = SUM_W'(fifo_wr_water_level) + SUM_W'(outstanding) + SUM_W'(len_calc);
    assign space_ok  = (space_sum <= SUM_W'(FIFO_WORDS));

    assign req_accept  = rd_bus.rd_req_valid && rd_bus.rd_req_ready;
    assign step        = ADDR_WIDTH'(32'(rd_bus.rd_req_len) * 32'(BEAT_BYTES));
    assign req_len_rem = REMAIN_W'(rd_bus.rd_req_len);

    // A frame_start arriving this very cycle counts the same as one latched earlier.
    assign restart = restart_pend | frame_start;
    assign busy    = (state != ST_IDLE);

    beat_credit_cnt #(
        .CNT_WIDTH (CNT_W),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .add_en     (req_accept),
        .add_len    (rd_bus.rd_req_len),
        .dec_en     (rd_bus.rd_data_valid),
        .count      (outstanding),
        .count_next (cnt_next),
        .underflow  (underflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ST_IDLE;
            addr                <= '0;
            remain              <= '0;
            restart_pend        <= 1'b0;
            frame_done          <= 1'b0;
            rd_bus.rd_req_valid <= 1'b0;
            rd_bus.rd_req_addr  <= FRAME_BASE;
            rd_bus.rd_req_len   <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        addr   <= FRAME_BASE;
                        remain <= REMAIN_W'(FRAME_BEATS);
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (restart) begin
                        state <= ST_DRAIN;
                    end else if (space_ok) begin
                        rd_bus.rd_req_addr  <= addr;
                        rd_bus.rd_req_len   <= len_calc;
                        rd_bus.rd_req_valid <= 1'b1;
                        state               <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Valid is never withdrawn; a restart only takes effect after the accept.
                    if (rd_bus.rd_req_ready) begin
                        rd_bus.rd_req_valid <= 1'b0;
                        addr                <= addr + step;
                        remain              <= remain - req_len_rem;
                        state <= (restart || remain == req_len_rem) ? ST_DRAIN : ST_CHECK;
                    end
                end
                ST_DRAIN: begin
                    // Looking at the next count lets frame_done follow the last beat by one cycle.
                    if (cnt_next == '0) begin
                        frame_done <= 1'b1;
                        if (restart) begin
                            addr   <= FRAME_BASE;
                            remain <= REMAIN_W'(FRAME_BEATS);
                            state  <= ST_CHECK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (state == ST_DRAIN && cnt_next == '0) restart_pend <= 1'b0;
            else if (frame_start && state != ST_IDLE) restart_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_err <= 1'b0;
        else if ((rd_bus.rd_data_valid && fifo_wr_full) || underflow) ovf_err <= 1'b1;
    end
endmodule
